// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger controller:
// FSM states, Avalon register addresses and register bit positions.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } ur_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_AVG    = 2'd3;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_CONT    = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_AVG_CLR = 3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_TIMEOUT = 2;
  localparam int unsigned STAT_OVERRUN = 3;

endpackage

// File: rtl/ultrasonic_echo_sync.sv
// Two-flop synchronizer for the sensor echo, with registered rise/fall
// pulses that are high in the first cycle echo_s shows the new level.
module ultrasonic_echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_in,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic echo_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_rise <= 1'b0;
      echo_fall <= 1'b0;
    end else begin
      echo_meta <= echo_in;
      echo_s    <= echo_meta;
      echo_rise <= echo_meta & ~echo_s;
      echo_fall <= ~echo_meta & echo_s;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// Avalon-MM controller for one HC-SR04-style ranger: trigger, echo timing,
// timeout, holdoff and interrupt. Define ULTRASONIC_AVG_EN for the 4-shot average.
module ultrasonic_ranger_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        echo_in,
  output logic        trig_out,
  output logic        irq
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  ur_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] result, res_val;
  logic             res_load, set_done, set_timeout;

  logic ctrl_cont, ctrl_irq_en, cont_nx, ien_nx;
  logic st_done, st_timeout, st_overrun;
  logic done_nx, tmo_nx, ovr_nx;
  logic [CNT_W-1:0] avg_val;

  logic wr, wr_ctrl, wr_status, start_req;
  logic echo_s, echo_rise, echo_fall;
  logic unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_ctrl      = wr && (address == ADDR_CTRL);
  assign wr_status    = wr && (address == ADDR_STATUS);
  assign start_req    = wr_ctrl & writedata[CTRL_START];
  assign unused_wdata = ^writedata[31:4];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ultrasonic_echo_sync u_echo_sync (
    .clk       (clk),
    .reset     (reset),
    .echo_in   (echo_in),
    .echo_s    (echo_s),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  // Gated by reset so an in-flight trigger drops without waiting for the edge.
  assign trig_out = (state == ST_TRIG) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    res_load    = 1'b0;
    res_val     = cnt;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req || ctrl_cont) begin
          state_nx = ST_TRIG;
          cnt_nx   = '0;
        end
      end
      ST_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nx = ST_WAIT_RISE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_nx = ST_MEASURE;
          cnt_nx   = CNT_W'(1);
        end else if (cnt == TMO_LAST) begin
          set_timeout = 1'b1;
          state_nx    = ST_HOLDOFF;
          cnt_nx      = '0;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          res_load = 1'b1;
          set_done = 1'b1;
          state_nx = ST_HOLDOFF;
          cnt_nx   = '0;
        end else if (cnt == TMO_MAX) begin
          res_load    = 1'b1;
          res_val     = '1;
          set_timeout = 1'b1;
          state_nx    = ST_HOLDOFF;
          cnt_nx      = '0;
        end else if (echo_s) begin
          cnt_nx = sat_inc(cnt);
        end
      end
      ST_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Hardware sets are OR-ed in after the W1C mask, so a same-cycle set wins.
  always_comb begin
    cont_nx = wr_ctrl ? writedata[CTRL_CONT]   : ctrl_cont;
    ien_nx  = wr_ctrl ? writedata[CTRL_IRQ_EN] : ctrl_irq_en;
    done_nx = (st_done    & ~(wr_status & writedata[STAT_DONE]))    | set_done;
    tmo_nx  = (st_timeout & ~(wr_status & writedata[STAT_TIMEOUT])) | set_timeout;
    ovr_nx  = (st_overrun & ~(wr_status & writedata[STAT_OVERRUN]))
            | (start_req && (state != ST_IDLE))
            | (set_done & st_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_cont   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      st_done     <= 1'b0;
      st_timeout  <= 1'b0;
      st_overrun  <= 1'b0;
      result      <= '0;
      irq         <= 1'b0;
    end else begin
      ctrl_cont   <= cont_nx;
      ctrl_irq_en <= ien_nx;
      st_done     <= done_nx;
      st_timeout  <= tmo_nx;
      st_overrun  <= ovr_nx;
      if (res_load) result <= res_val;
      irq         <= ien_nx & (done_nx | tmo_nx);
    end
  end

`ifdef ULTRASONIC_AVG_EN
  logic [CNT_W-1:0] avg_buf [4];
  logic [2:0]       avg_cnt;
  logic [CNT_W+1:0] avg_sum;

  always_ff @(posedge clk) begin
    if (reset || (wr_ctrl && writedata[CTRL_AVG_CLR])) begin
      for (int unsigned i = 0; i < 4; i++) avg_buf[i] <= '0;
      avg_cnt <= '0;
    end else if (set_done) begin
      avg_buf[0] <= res_val;
      for (int unsigned i = 1; i < 4; i++) avg_buf[i] <= avg_buf[i-1];
      if (avg_cnt != 3'd4) avg_cnt <= avg_cnt + 3'd1;
    end
  end

  always_comb begin
    avg_sum = {2'b00, avg_buf[0]} + {2'b00, avg_buf[1]}
            + {2'b00, avg_buf[2]} + {2'b00, avg_buf[3]};
    avg_val = (avg_cnt == 3'd4) ? avg_sum[CNT_W+1:2] : '0;
  end
`else
  assign avg_val = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_CONT]   = ctrl_cont;
        readdata[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY]    = (state != ST_IDLE);
        readdata[STAT_DONE]    = st_done;
        readdata[STAT_TIMEOUT] = st_timeout;
        readdata[STAT_OVERRUN] = st_overrun;
      end
      ADDR_RESULT: readdata[CNT_W-1:0] = result;
      ADDR_AVG:    readdata[CNT_W-1:0] = avg_val;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: doc/ultrasonic_ranger_ctrl.md
Name: ultrasonic_ranger_ctrl

Overview:
- Avalon-MM slave controller that sequences one HC-SR04-style ultrasonic sensor.
- Generates the trigger pulse and times the echo pulse in clk cycles.
- Enforces a timeout and an inter-shot holdoff, and raises an interrupt on completion.
- Sits beside the existing 2-bit ultrasonic output PIO and lets software range without bit-banging.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo width (30 ms).
- HOLDOFF_CYCLES, 3000000: dead time after each shot before the next may start (60 ms).
- CNT_W, 24: width of the cycle counter and the result field; must hold all three values above.

Ports:
- clk, in, 1: system clock. One clock domain.
- reset, in, 1: reset, synchronous, active-high.
- address, in, 2: register select.
- chipselect, in, 1: Avalon chip select.
- write_n, in, 1: Avalon write strobe, active-low.
- writedata, in, 32: write data.
- readdata, out, 32: read data; combinational, zero wait states, unused bits 0.
- echo_in, in, 1: asynchronous echo from the sensor.
- trig_out, out, 1: trigger to the sensor.
- irq, out, 1: level interrupt.

Behaviour:
- Write strobe: wr = chipselect & ~write_n.
- Reset values: trig_out=0, irq=0, CTRL=0, STATUS=0, RESULT=0. FSM returns to IDLE and counter=0.
- Reset applied mid-shot aborts the shot on the next edge and drives trig_out low immediately.
- Register map:
  - addr0 CTRL (R/W): bit0 START (write-1 pulse, reads 0), bit1 CONT (continuous), bit2 IRQ_EN.
  - addr1 STATUS: bit0 BUSY (RO, state!=IDLE), bit1 DONE (W1C), bit2 TIMEOUT (W1C), bit3 OVERRUN (W1C).
  - addr2 RESULT (RO): echo width in cycles, [CNT_W-1:0].
  - addr3 AVG (RO): see Optional Feature.
- echo_in passes through a 2-flop synchronizer, giving echo_s. Rise and fall detect are taken on echo_s.
- FSM state IDLE:
  - Leave when a START write occurs or CONT=1: go to TRIG, counter=0, trig_out=1 on the next cycle.
- FSM state TRIG:
  - trig_out=1 for exactly TRIG_CYCLES cycles, then trig_out=0, counter=0, go to WAIT_RISE.
- FSM state WAIT_RISE:
  - echo_s rise: go to MEASURE, counter=1.
  - counter reaches TIMEOUT_CYCLES: set TIMEOUT, RESULT unchanged, go to HOLDOFF.
- FSM state MEASURE:
  - Counter increments each cycle while echo_s=1.
  - echo_s fall: RESULT=counter (equals echo-high cycles N), set DONE, go to HOLDOFF.
  - counter reaches TIMEOUT_CYCLES: RESULT=all ones, set TIMEOUT, go to HOLDOFF.
- FSM state HOLDOFF:
  - Count HOLDOFF_CYCLES, then go to IDLE.
  - echo activity is ignored.
- START written while BUSY: ignored, and OVERRUN is set.
- DONE already set when a new DONE is set: OVERRUN is set as well. RESULT is overwritten.
- W1C clear landing in the same cycle as a hardware set: the set wins.
- CONT cleared mid-shot: the current shot completes, then the FSM stays in IDLE.
- irq = IRQ_EN & (DONE | TIMEOUT), registered; it deasserts the cycle after the W1C.
- Counter saturates and never wraps.

Optional Feature:
- Macro: ULTRASONIC_AVG_EN.
- Defined:
  - A 4-entry shift buffer of valid RESULTs (DONE shots only; timeouts are excluded).
  - AVG = sum>>2 once 4 samples are present; AVG = 0 before that.
  - Buffer cleared on reset, and on a CTRL write with bit3=1.
- Undefined: addr3 reads 0, no buffer is built, and CTRL bit3 is ignored.

Decomposition:
- Package ultrasonic_pkg holds:
  - the FSM state enum;
  - address constants ADDR_CTRL/STATUS/RESULT/AVG;
  - CTRL and STATUS bit-position constants.
- Sub-module ultrasonic_echo_sync: 2-flop synchronizer plus registered rise/fall pulse outputs.

Test Plan (TRIG_CYCLES=5, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=20, CNT_W=8):
- Basic shot: write CTRL=0x1, echo high for 37 cycles after trig falls -> trig_out high 5 cycles; RESULT=37; DONE=1; BUSY clears 20 cycles after the fall.
- No echo: write START, echo held low -> TIMEOUT=1 after 100 cycles in WAIT_RISE; RESULT keeps its old value; DONE=0.
- Stuck echo: echo held high -> RESULT=0xFF, TIMEOUT=1.
- Interrupt and status handling:
  - IRQ_EN=1, shot completes -> irq=1.
  - Write STATUS=0x2 -> irq=0 the next cycle.
  - START written during MEASURE -> OVERRUN=1, no second shot.
- Continuous mode: CONT=1 with echoes of 10, 20, 30, 40 cycles -> four shots back to back with a 20-cycle holdoff; with ULTRASONIC_AVG_EN defined, AVG=25.
- Reset mid-TRIG: reset high for 1 cycle -> trig_out=0, state IDLE, all registers 0.
